// File: rtl/chain_constraint_solver.sv
// Chain relaxation sequencer: verlet strobe, anchor pin, per-link clamp; floor clamp when CONSTRAINT_FLOOR_EN.
// Latency: step accepted in IDLE at cycle 0, done pulses at cycle 2 + ITERATIONS*NUM_NODES.
// Backpressure: none; step_req is ignored while busy, and a held request restarts from the next IDLE cycle.
module chain_constraint_solver #(
    parameter int NUM_NODES  = 8,
    parameter int ITERATIONS = 2,
    parameter int BASE_X     = 200,
    parameter int BASE_Y     = 0,
    parameter int DIST       = 10,
    parameter int FLOOR_Y    = 400
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   step_req,
    input  logic [32*NUM_NODES-1:0] x_pos_bus,
    input  logic [32*NUM_NODES-1:0] y_pos_bus,
    output logic                   verlet_state,
    output logic [NUM_NODES-1:0]   fix_constraint_state,
    output logic [31:0]            x_fix_constraint,
    output logic [31:0]            y_fix_constraint,
    output logic                   busy,
    output logic                   done
);

    localparam int LW = $clog2(NUM_NODES);
    localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [LW-1:0] LAST_LINK = LW'(NUM_NODES - 1);
    localparam logic [IW-1:0] LAST_ITER = IW'(ITERATIONS - 1);
    localparam logic signed [31:0] DMAX = 32'(DIST);
    localparam logic signed [31:0] DMIN = -32'(DIST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VERLET,
        S_PIN,
        S_LINK,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [LW-1:0]   link_idx, link_nxt, par_idx;
    logic [IW-1:0]   iter, iter_nxt;

    logic signed [31:0] x_node [NUM_NODES];
    logic signed [31:0] y_node [NUM_NODES];
    logic signed [31:0] fix_x, fix_y;

    for (genvar g = 0; g < NUM_NODES; g++) begin : g_unpack
        assign x_node[g] = x_pos_bus[32*g +: 32];
        assign y_node[g] = y_pos_bus[32*g +: 32];
    end

    function automatic logic signed [31:0] clamp_off(input logic signed [31:0] d);
        if (d > DMAX) return DMAX;
        if (d < DMIN) return DMIN;
        return d;
    endfunction

    assign par_idx = link_idx - LW'(1);

`ifdef CONSTRAINT_FLOOR_EN
    localparam logic signed [31:0] FLOOR_S = 32'(FLOOR_Y);
`else
    logic unused_floor;
    assign unused_floor = ^32'(FLOOR_Y);
`endif

    // Offsets wrap in 32 bits before clamping; the parent was written last cycle, so the bus is current.
    always_comb begin
        fix_x = x_node[par_idx] + clamp_off(x_node[link_idx] - x_node[par_idx]);
        fix_y = y_node[par_idx] + clamp_off(y_node[link_idx] - y_node[par_idx]);
`ifdef CONSTRAINT_FLOOR_EN
        if (fix_y > FLOOR_S) fix_y = FLOOR_S;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            link_idx <= '0;
            iter     <= '0;
        end else begin
            state    <= state_nxt;
            link_idx <= link_nxt;
            iter     <= iter_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        link_nxt             = link_idx;
        iter_nxt             = iter;
        verlet_state         = 1'b0;
        fix_constraint_state = '0;
        x_fix_constraint     = '0;
        y_fix_constraint     = '0;
        busy                 = 1'b0;
        done                 = 1'b0;
        case (state)
            S_IDLE: begin
                link_nxt = '0;
                iter_nxt = '0;
                if (step_req) state_nxt = S_VERLET;
            end
            S_VERLET: begin
                busy         = 1'b1;
                verlet_state = 1'b1;
                state_nxt    = S_PIN;
            end
            S_PIN: begin
                busy                    = 1'b1;
                fix_constraint_state[0] = 1'b1;
                x_fix_constraint        = 32'(BASE_X);
                y_fix_constraint        = 32'(BASE_Y);
                link_nxt                = LW'(1);
                state_nxt               = S_LINK;
            end
            S_LINK: begin
                busy                 = 1'b1;
                fix_constraint_state = {{(NUM_NODES-1){1'b0}}, 1'b1} << link_idx;
                x_fix_constraint     = fix_x;
                y_fix_constraint     = fix_y;
                if (link_idx != LAST_LINK) begin
                    link_nxt = link_idx + LW'(1);
                end else if (iter != LAST_ITER) begin
                    iter_nxt  = iter + IW'(1);
                    state_nxt = S_PIN;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                link_nxt  = '0;
                iter_nxt  = '0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_chain_constraint_solver.sv
// Bench for chain_constraint_solver: node-array model on the buses, relaxation reference model, event scoreboard.
module tb_chain_constraint_solver;
    localparam int N  = 8;
    localparam int IT = 2;
    localparam int BX = 200;
    localparam int BY = 0;
    localparam int D  = 10;
    localparam int FY = 400;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic step_req = 1'b1;
    logic [32*N-1:0] x_pos_bus, y_pos_bus;
    logic verlet_state;
    logic [N-1:0] fix_constraint_state;
    logic [31:0] x_fix_constraint, y_fix_constraint;
    logic busy, done;

    int nx[N], ny[N];     // node registers (environment)
    int ldx[N], ldy[N];   // values to preload into the nodes
    int vdx[N], vdy[N];   // displacement applied by a verlet strobe
    int mx[N], my[N];     // reference model positions
    logic load_en = 1'b0;
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int kind;   // 0 verlet, 1 fix, 2 done
        int node;
        int x;
        int y;
        int at;
    } ev_t;
    ev_t exp_q[$];

    chain_constraint_solver #(
        .NUM_NODES(N), .ITERATIONS(IT), .BASE_X(BX), .BASE_Y(BY), .DIST(D), .FLOOR_Y(FY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .step_req(step_req),
        .x_pos_bus(x_pos_bus),
        .y_pos_bus(y_pos_bus),
        .verlet_state(verlet_state),
        .fix_constraint_state(fix_constraint_state),
        .x_fix_constraint(x_fix_constraint),
        .y_fix_constraint(y_fix_constraint),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_bus
        assign x_pos_bus[32*g +: 32] = nx[g];
        assign y_pos_bus[32*g +: 32] = ny[g];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (load_en) begin
                nx[i] <= ldx[i];
                ny[i] <= ldy[i];
            end else if (verlet_state) begin
                nx[i] <= nx[i] + vdx[i];
                ny[i] <= ny[i] + vdy[i];
            end else if (fix_constraint_state[i]) begin
                nx[i] <= x_fix_constraint;
                ny[i] <= y_fix_constraint;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, $signed(act), $signed(exp_v), cyc);
        end
    endtask

    function automatic int clampd(input int d);
        if (d > D) return D;
        if (d < -D) return -D;
        return d;
    endfunction

    // One step of the reference: displace, then ITERATIONS passes of pin-and-relax from the anchor outward.
    task automatic plan_step(input int c0, output int dcyc);
        ev_t e;
        int t;
        t = c0 + 1;
        e = '{0, 0, 0, 0, t};
        exp_q.push_back(e);
        for (int i = 0; i < N; i++) begin
            mx[i] += vdx[i];
            my[i] += vdy[i];
        end
        for (int it = 0; it < IT; it++) begin
            t++;
            mx[0] = BX;
            my[0] = BY;
            e = '{1, 0, BX, BY, t};
            exp_q.push_back(e);
            for (int i = 1; i < N; i++) begin
                t++;
                mx[i] = mx[i-1] + clampd(mx[i] - mx[i-1]);
                my[i] = my[i-1] + clampd(my[i] - my[i-1]);
`ifdef CONSTRAINT_FLOOR_EN
                if (my[i] > FY) my[i] = FY;
`endif
                e = '{1, i, mx[i], my[i], t};
                exp_q.push_back(e);
            end
        end
        t++;
        e = '{2, 0, 0, 0, t};
        exp_q.push_back(e);
        dcyc = t;
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        int k;
        if (reset) begin
            chk("strobe_onehot", 32'($countones({verlet_state, fix_constraint_state}) <= 1), 32'd1);
            if (fix_constraint_state == '0) begin
                chk("x_fix_idle", x_fix_constraint, 32'd0);
                chk("y_fix_idle", y_fix_constraint, 32'd0);
            end
            if (verlet_state || (|fix_constraint_state) || done) begin
                k = done ? 2 : (verlet_state ? 0 : 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", k, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", 32'(k), 32'(e.kind));
                    chk("event_cycle", 32'(cyc), 32'(e.at));
                    chk("busy", 32'(busy), 32'(e.kind != 2));
                    if (e.kind == 1) begin
                        chk("fix_strobe", 32'(fix_constraint_state), 32'(1) << e.node);
                        chk("x_fix", x_fix_constraint, 32'(e.x));
                        chk("y_fix", y_fix_constraint, 32'(e.y));
                    end
                end
            end
        end
    end

    task automatic load_nodes();
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            mx[i] = ldx[i];
            my[i] = ldy[i];
        end
    endtask

    task automatic run_step(input bit held);
        int c0, d1, d2;
        load_nodes();
        c0 = cyc;
        step_req = 1'b1;
        plan_step(c0, d1);
        d2 = d1;
        if (held) plan_step(d1 + 1, d2);
        @(negedge clk);
        if (held) while (cyc < d1 + 2) @(negedge clk);
        step_req = 1'b0;
        while (cyc < d2 + 2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic rest_chain();
        for (int i = 0; i < N; i++) begin
            ldx[i] = BX;
            ldy[i] = BY + D * i;
            vdx[i] = 0;
            vdy[i] = 0;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, d1;
        // Reset held with a pending request: nothing may start.
        repeat (3) begin
            @(negedge clk);
            chk("rst_verlet", 32'(verlet_state), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_fix", 32'(fix_constraint_state), 32'd0);
        end
        step_req = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Chain at rest: every write reproduces the current position.
        rest_chain();
        run_step(1'b0);

        // Stretched link at node 3.
        rest_chain();
        ldx[3] = 230;
        ldy[3] = 45;
        run_step(1'b0);

        // Displaced anchor and a negative pull on node 1.
        rest_chain();
        ldx[0] = 205;
        ldy[0] = 3;
        ldx[1] = 180;
        ldy[1] = -7;
        run_step(1'b0);

        // Node 5 far below node 4 (floor-relevant when the feature is built in).
        rest_chain();
        ldy[4] = 395;
        ldy[5] = 500;
        run_step(1'b0);

        // Randomized chains and displacements; one round with the request held.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                if (r % 3 == 0) begin
                    ldx[i] = int'($urandom);
                    ldy[i] = int'($urandom);
                end else begin
                    ldx[i] = BX + int'($urandom_range(0, 80)) - 40;
                    ldy[i] = D * i + int'($urandom_range(0, 80)) - 40;
                end
                vdx[i] = int'($urandom_range(0, 30)) - 15;
                vdy[i] = int'($urandom_range(0, 30)) - 15;
            end
            run_step(r == 5);
        end

        // Reset seven cycles into a step: outputs clear at once and no done follows.
        rest_chain();
        load_nodes();
        c0 = cyc;
        step_req = 1'b1;
        plan_step(c0, d1);
        while (cyc < c0 + 7) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_verlet", 32'(verlet_state), 32'd0);
        chk("midrst_fix", 32'(fix_constraint_state), 32'd0);
        chk("midrst_x_fix", x_fix_constraint, 32'd0);
        chk("midrst_y_fix", y_fix_constraint, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("midrst_hold_verlet", 32'(verlet_state), 32'd0);
            chk("midrst_hold_busy", 32'(busy), 32'd0);
        end
        step_req = 1'b0;
        reset = 1'b1;
        repeat (25) @(negedge clk);

        // A normal step still works after the interrupted one.
        rest_chain();
        run_step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
